mem_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between two requesters: instruction-fetch side (I) and data-access side (D).
- Sits between the fetch/load-store logic of the multi-cycle and pipelined CPU variants and the shared memory model.
- Sequences each transaction with an FSM and latency counter.
- Returns read data or write completion to the winning requester with a one-cycle valid pulse.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between an
// instruction-fetch requester (I, reads only) and a data-access requester (D).
// Each transaction runs IDLE -> GRANT -> WAIT* -> RESP -> IDLE.
// Optional feature macro ARB_ROUND_ROBIN_EN: when defined, a simultaneous
// I/D request is won by the side that did not own the previous transaction.
// When undefined, D always beats I.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              owner_d, owner_d_nxt;  // 1 = D owns the transaction, 0 = I
  logic              wr, wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              pick_d;

  // Arbitration: which side wins if a request is accepted this cycle
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_req & (~i_req | ~owner_d);
`else
    pick_d = d_req;
`endif
  end

  // Next-state, counter and transaction latch logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    owner_d_nxt = owner_d;
    wr_nxt      = wr;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    case (state)
      S_IDLE: begin
        if (i_req | d_req) begin
          state_nxt   = S_GRANT;
          owner_d_nxt = pick_d;
          wr_nxt      = pick_d & d_wr;
          addr_nxt    = pick_d ? d_addr : i_addr;
          wdata_nxt   = pick_d ? d_wdata : '0;
        end
      end
      S_GRANT: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and latched transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      wr        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      owner_d   <= owner_d_nxt;
      wr        <= wr_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

  // Registered control outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      i_gnt   <= (state_nxt == S_GRANT) & ~owner_d_nxt;
      d_gnt   <= (state_nxt == S_GRANT) & owner_d_nxt;
      i_valid <= (state_nxt == S_RESP) & ~owner_d_nxt;
      d_valid <= (state_nxt == S_RESP) & owner_d_nxt;
      mem_en  <= (state_nxt == S_GRANT);
      mem_wr  <= (state_nxt == S_GRANT) & owner_d_nxt & wr_nxt;
      busy    <= (state_nxt != S_IDLE);
    end
  end

  // Read data passes straight through to the owner during its RESP cycle
  always_comb begin
    i_rdata = i_valid ? mem_rdata : '0;
    d_rdata = (d_valid & ~wr) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level timing model of the arbiter (LATENCY = 4).
module tb_mem_arbiter;

  localparam int unsigned LAT = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_req, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_wr, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nxt();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_wr, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000000", {i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_wr, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      smp();
      checks++;
      if ({mem_en, busy, i_gnt, d_gnt} !== 4'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %b exp 0000", c, {mem_en, busy, i_gnt, d_gnt});
      end
      nxt();
    end
  endtask

  task automatic test_i_read();
    i_req = 1'b1; i_addr = 16'h0010;
    for (int c = 0; c < 6; c++) begin
      logic [3:0]    exp_gv;
      logic [DW-1:0] exp_ir;
      nxt();
      mem_rdata = (c == 4) ? 16'hA5A5 : 16'h0F0F;
      smp();
      exp_gv = {c == 0, c == 4, 1'b0, 1'b0};
      exp_ir = (c == 4) ? 16'hA5A5 : 16'h0000;
      checks++;
      if ({i_gnt, i_valid, d_gnt, d_valid} !== exp_gv) begin
        errors++;
        $display("FAIL iread_gv cyc=%0d got %b exp %b", c, {i_gnt, i_valid, d_gnt, d_valid}, exp_gv);
      end
      checks++;
      if (i_rdata !== exp_ir || d_rdata !== 16'h0) begin
        errors++;
        $display("FAIL iread_rdata cyc=%0d got i=%h d=%h exp i=%h d=0000", c, i_rdata, d_rdata, exp_ir);
      end
      checks++;
      if (busy !== (c <= 4)) begin
        errors++;
        $display("FAIL iread_busy cyc=%0d got %b exp %b", c, busy, c <= 4);
      end
      if (c == 0) begin
        checks++;
        if ({mem_en, mem_wr} !== 2'b10 || mem_addr !== 16'h0010) begin
          errors++;
          $display("FAIL iread_mem got en=%b wr=%b addr=%h exp en=1 wr=0 addr=0010", mem_en, mem_wr, mem_addr);
        end
      end
      if (c == 4) i_req = 1'b0;
    end
    nxt();
  endtask

  task automatic test_simultaneous();
    do_reset();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    i_req = 1'b1; i_addr = 16'h0020;
    for (int c = 0; c < 12; c++) begin
      logic [3:0]    exp_gv;
      logic [DW-1:0] exp_ir;
      logic          exp_busy;
      nxt();
      mem_rdata = DW'(16'h1000 + c);
      smp();
      exp_gv   = {c == 6, c == 10, c == 0, c == 4};
      exp_ir   = (c == 10) ? DW'(16'h1000 + c) : 16'h0000;
      exp_busy = (c <= 4) || (c >= 6 && c <= 10);
      checks++;
      if ({i_gnt, i_valid, d_gnt, d_valid} !== exp_gv) begin
        errors++;
        $display("FAIL simul_gv cyc=%0d got %b exp %b", c, {i_gnt, i_valid, d_gnt, d_valid}, exp_gv);
      end
      checks++;
      if (i_rdata !== exp_ir || d_rdata !== 16'h0 || busy !== exp_busy) begin
        errors++;
        $display("FAIL simul_data cyc=%0d got i=%h d=%h busy=%b exp i=%h d=0000 busy=%b",
                 c, i_rdata, d_rdata, busy, exp_ir, exp_busy);
      end
      if (c == 0) begin
        checks++;
        if ({mem_en, mem_wr} !== 2'b11 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
          errors++;
          $display("FAIL simul_dwrite got en=%b wr=%b addr=%h wdata=%h exp en=1 wr=1 addr=0200 wdata=1234",
                   mem_en, mem_wr, mem_addr, mem_wdata);
        end
      end
      if (c == 6) begin
        checks++;
        if ({mem_en, mem_wr} !== 2'b10 || mem_addr !== 16'h0020) begin
          errors++;
          $display("FAIL simul_iread got en=%b wr=%b addr=%h exp en=1 wr=0 addr=0020", mem_en, mem_wr, mem_addr);
        end
      end
      if (c == 4) d_req = 1'b0;
      if (c == 10) i_req = 1'b0;
    end
    nxt();
  endtask

  task automatic test_contention();
    int  gnt_cyc[$];
    bit  gnt_d[$];
    bit  exp_d[4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    i_req = 1'b1; i_addr = 16'h0080;
    for (int c = 0; c < 24; c++) begin
      nxt();
      mem_rdata = DW'($urandom);
      smp();
      if (i_gnt === 1'b1 || d_gnt === 1'b1) begin
        gnt_cyc.push_back(c);
        gnt_d.push_back(d_gnt === 1'b1);
      end
      checks++;
      if ((i_gnt & d_gnt) !== 1'b0) begin
        errors++;
        $display("FAIL cont_dual_gnt cyc=%0d got i=%b d=%b exp one at most", c, i_gnt, d_gnt);
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    nxt();
    checks++;
    if (gnt_cyc.size() != 4) begin
      errors++;
      $display("FAIL cont_count got %0d exp 4", gnt_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gnt_d[k] != exp_d[k] || gnt_cyc[k] != k * int'(LAT + 2)) begin
          errors++;
          $display("FAIL cont_order idx=%0d got d=%b cyc=%0d exp d=%b cyc=%0d",
                   k, gnt_d[k], gnt_cyc[k], exp_d[k], k * int'(LAT + 2));
        end
      end
    end
    for (int c = 0; c < int'(LAT) + 2; c++) nxt();
  endtask

  task automatic test_reset_midop();
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
    for (int c = 0; c < 3; c++) begin
      nxt();
      smp();
      if (c == 0) begin
        checks++;
        if (d_gnt !== 1'b1) begin
          errors++;
          $display("FAIL midop_first_gnt got %b exp 1", d_gnt);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_wr, busy} !== 7'b0 || mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL midop_async got ctrl=%b addr=%h exp ctrl=0000000 addr=0000",
               {i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_wr, busy}, mem_addr);
    end
    for (int c = 0; c < 5; c++) begin
      nxt();
      mem_rdata = 16'h7777;
      smp();
      checks++;
      if ({d_valid, busy, d_rdata} !== {2'b00, 16'h0}) begin
        errors++;
        $display("FAIL midop_held cyc=%0d got valid=%b busy=%b rdata=%h exp 0 0 0000", c, d_valid, busy, d_rdata);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic [DW-1:0] exp_dr;
      nxt();
      mem_rdata = (c == 4) ? 16'hC3C3 : 16'h7777;
      smp();
      exp_dr = (c == 4) ? 16'hC3C3 : 16'h0000;
      checks++;
      if ({d_gnt, d_valid, i_gnt, i_valid} !== {c == 0, c == 4, 2'b00} || d_rdata !== exp_dr) begin
        errors++;
        $display("FAIL midop_redo cyc=%0d got gnt=%b valid=%b rdata=%h exp gnt=%b valid=%b rdata=%h",
                 c, d_gnt, d_valid, d_rdata, c == 0, c == 4, exp_dr);
      end
      if (c == 0) begin
        checks++;
        if (mem_addr !== 16'h0300) begin
          errors++;
          $display("FAIL midop_addr got %h exp 0300", mem_addr);
        end
      end
      if (c == 4) d_req = 1'b0;
    end
    nxt();
  endtask

  task automatic test_dropped();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    for (int c = 0; c < 7; c++) begin
      logic [DW-1:0] exp_dr;
      nxt();
      mem_rdata = (c == 4) ? 16'h5A5A : 16'h1111;
      smp();
      exp_dr = (c == 4) ? 16'h5A5A : 16'h0000;
      checks++;
      if ({d_gnt, d_valid} !== {c == 0, c == 4} || d_rdata !== exp_dr) begin
        errors++;
        $display("FAIL drop_d cyc=%0d got gnt=%b valid=%b rdata=%h exp gnt=%b valid=%b rdata=%h",
                 c, d_gnt, d_valid, d_rdata, c == 0, c == 4, exp_dr);
      end
      checks++;
      if (busy !== (c <= 4) || (c >= 5 && mem_en !== 1'b0)) begin
        errors++;
        $display("FAIL drop_busy cyc=%0d got busy=%b en=%b exp busy=%b en=0", c, busy, mem_en, c <= 4);
      end
      if (c == 2) begin
        checks++;
        if (mem_addr !== 16'h0400) begin
          errors++;
          $display("FAIL drop_addr got %h exp 0400", mem_addr);
        end
      end
      if (c == 1) begin
        d_req = 1'b0;
        d_addr = 16'hFFFF;
      end
    end
    nxt();
  endtask

  // Randomized traffic against a transaction-level model: an accepted request
  // at the end of idle cycle T grants in T+1, responds in T+1+LAT, and the
  // arbiter is free to accept again at the end of cycle T+LAT+2.
  task automatic test_random(input int n);
    longint        free_at = 0;
    longint        g_cyc = -1;
    longint        v_cyc = -1;
    bit            last_d = 1'b0;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            i_pend = 1'b0, d_pend = 1'b0;
    bit            i_acc = 1'b0, d_acc = 1'b0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      logic [3:0]    exp_gv;
      logic [2:0]    exp_ewb;
      logic [DW-1:0] exp_ir, exp_dr;
      longint        cl;
      bit            win_d;
      cl = longint'(c);
      if (!i_pend) begin
        if ($urandom_range(1, 0) == 1) begin
          i_pend = 1'b1; i_acc = 1'b0; i_req = 1'b1; i_addr = AW'($urandom);
        end else begin
          i_req = 1'b0;
        end
      end else if (i_acc) begin
        if ($urandom_range(3, 0) == 0) i_req = 1'b0;
        i_addr = AW'($urandom);
      end
      if (!d_pend) begin
        if ($urandom_range(1, 0) == 1) begin
          d_pend = 1'b1; d_acc = 1'b0; d_req = 1'b1;
          d_wr = 1'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end else if (d_acc) begin
        if ($urandom_range(3, 0) == 0) d_req = 1'b0;
        d_addr = AW'($urandom);
        d_wdata = DW'($urandom);
      end
      mem_rdata = DW'($urandom);
      smp();
      exp_gv  = {cl == g_cyc && !last_d, cl == v_cyc && !last_d, cl == g_cyc && last_d, cl == v_cyc && last_d};
      exp_ewb = {cl == g_cyc, cl == g_cyc && last_d && m_wr, cl >= g_cyc && cl <= v_cyc};
      exp_ir  = (cl == v_cyc && !last_d) ? mem_rdata : '0;
      exp_dr  = (cl == v_cyc && last_d && !m_wr) ? mem_rdata : '0;
      checks++;
      if ({i_gnt, i_valid, d_gnt, d_valid} !== exp_gv) begin
        errors++;
        $display("FAIL rnd_gv cyc=%0d got %b exp %b", c, {i_gnt, i_valid, d_gnt, d_valid}, exp_gv);
      end
      checks++;
      if ({mem_en, mem_wr, busy} !== exp_ewb) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got %b exp %b", c, {mem_en, mem_wr, busy}, exp_ewb);
      end
      checks++;
      if (mem_addr !== m_addr) begin
        errors++;
        $display("FAIL rnd_addr cyc=%0d got %h exp %h", c, mem_addr, m_addr);
      end
      checks++;
      if (i_rdata !== exp_ir || d_rdata !== exp_dr) begin
        errors++;
        $display("FAIL rnd_rdata cyc=%0d got i=%h d=%h exp i=%h d=%h", c, i_rdata, d_rdata, exp_ir, exp_dr);
      end
      if (exp_ewb[1]) begin
        checks++;
        if (mem_wdata !== m_wdata) begin
          errors++;
          $display("FAIL rnd_wdata cyc=%0d got %h exp %h", c, mem_wdata, m_wdata);
        end
      end
      if (cl == v_cyc) begin
        if (last_d) d_pend = 1'b0;
        else        i_pend = 1'b0;
      end
      if (cl >= free_at && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = d_req && (!i_req || !last_d);
`else
        win_d = d_req;
`endif
        last_d  = win_d;
        m_wr    = win_d && d_wr;
        m_addr  = win_d ? d_addr : i_addr;
        m_wdata = d_wdata;
        g_cyc   = cl + 1;
        v_cyc   = cl + 1 + longint'(LAT);
        free_at = cl + 2 + longint'(LAT);
        if (win_d) d_acc = 1'b1;
        else       i_acc = 1'b1;
      end
      nxt();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_i_read();
    test_simultaneous();
    test_contention();
    test_reset_midop();
    test_dropped();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
